// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready flow control, flush and a saturating stall counter.
// Define EX_MEM_PIPE_SKID_EN to add a one-entry skid buffer and a registered ready_o.
module ex_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] pc_branch_i,
    input  logic              zero_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [RD_W-1:0]   rd_addr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [DATA_W-1:0] pc_branch_o,
    output logic              zero_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [RD_W-1:0]   rd_addr_o,
    output logic              branch_taken_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Handshake: a beat moves on a rising edge when valid and ready are both high
    // on that side; valid never depends on ready, and flush_i overrides both sides.

    localparam int CTRL_LSB = RD_W;
    localparam int ZERO_BIT = RD_W + CTRL_W;
    localparam int PC_LSB   = ZERO_BIT + 1;
    localparam int RS2_LSB  = PC_LSB + DATA_W;
    localparam int ALU_LSB  = RS2_LSB + DATA_W;
    localparam int BEAT_W   = ALU_LSB + DATA_W;

    logic [BEAT_W-1:0] beat_in;
    logic [BEAT_W-1:0] out_q, out_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              xfer_in;
    logic              out_free;

    assign beat_in  = {alu_result_i, rs2_data_i, pc_branch_i, zero_i, ctrl_i, rd_addr_i};
    assign out_free = ~valid_q | ready_i;
    assign xfer_in  = valid_i & ready_o & ~flush_i;

`ifdef EX_MEM_PIPE_SKID_EN
    logic [BEAT_W-1:0] skid_q, skid_d;
    logic              skid_full_q, skid_full_d;
    logic              ready_q, ready_d;

    assign ready_o = ready_q;

    always_comb begin
        out_d       = out_q;
        valid_d     = valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (flush_i) begin
            valid_d                       = 1'b0;
            out_d[CTRL_LSB +: CTRL_W]     = '0;
            skid_full_d                   = 1'b0;
        end else if (out_free) begin
            // The skid beat is older than anything arriving now, so it goes first.
            if (skid_full_q) begin
                out_d       = skid_q;
                valid_d     = 1'b1;
                skid_full_d = xfer_in;
                if (xfer_in) skid_d = beat_in;
            end else if (xfer_in) begin
                out_d   = beat_in;
                valid_d = 1'b1;
            end else begin
                valid_d                   = 1'b0;
                out_d[CTRL_LSB +: CTRL_W] = '0;
            end
        end else if (xfer_in) begin
            skid_d      = beat_in;
            skid_full_d = 1'b1;
        end
        ready_d = ~skid_full_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            ready_q     <= ready_d;
        end
    end
`else
    assign ready_o = ready_i | ~valid_q;

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d                   = 1'b0;
            out_d[CTRL_LSB +: CTRL_W] = '0;
        end else if (xfer_in) begin
            out_d   = beat_in;
            valid_d = 1'b1;
        end else if (out_free) begin
            valid_d                   = 1'b0;
            out_d[CTRL_LSB +: CTRL_W] = '0;
        end
    end
`endif

    // Saturates at all-ones; flush does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !ready_i && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_q       <= out_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o        = valid_q;
    assign alu_result_o   = out_q[ALU_LSB +: DATA_W];
    assign rs2_data_o     = out_q[RS2_LSB +: DATA_W];
    assign pc_branch_o    = out_q[PC_LSB +: DATA_W];
    assign zero_o         = out_q[ZERO_BIT];
    assign ctrl_o         = out_q[CTRL_LSB +: CTRL_W];
    assign rd_addr_o      = out_q[RD_W-1:0];
    assign branch_taken_o = valid_q & ctrl_o[CTRL_W-1] & zero_o;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: queue-based reference model checked every cycle plus directed literal checks.
module tb_ex_mem_pipe;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef EX_MEM_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic        zero;
    logic [4:0]  ctrl;
    logic [4:0]  rd;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b1, zero_i = 1'b0;
  logic [31:0] alu_result_i = '0, rs2_data_i = '0, pc_branch_i = '0;
  logic [4:0]  ctrl_i = '0, rd_addr_i = '0;
  logic        ready_o, valid_o, zero_o, branch_taken_o;
  logic [31:0] alu_result_o, rs2_data_o, pc_branch_o;
  logic [4:0]  ctrl_o, rd_addr_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  beat_t last_beat;
  logic [CNT_W-1:0] exp_cnt;

  ex_mem_pipe #(.DATA_W(32), .CTRL_W(5), .RD_W(5), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .pc_branch_i(pc_branch_i),
    .zero_i(zero_i), .ctrl_i(ctrl_i), .rd_addr_i(rd_addr_i), .valid_o(valid_o),
    .ready_i(ready_i), .alu_result_o(alu_result_o), .rs2_data_o(rs2_data_o),
    .pc_branch_o(pc_branch_o), .zero_o(zero_o), .ctrl_o(ctrl_o), .rd_addr_o(rd_addr_o),
    .branch_taken_o(branch_taken_o), .stall_cnt_o(stall_cnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: contents of the stage as an ordered queue
  initial begin
    beat_t in_b;
    bit rdy_now;
    last_beat = '0;
    exp_cnt = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        last_beat = '0;
        exp_cnt = '0;
      end else begin
        rdy_now = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || ready_i);
        in_b = '{alu: alu_result_i, rs2: rs2_data_i, pc: pc_branch_i, zero: zero_i,
                 ctrl: ctrl_i, rd: rd_addr_i};
        if (exp_q.size() > 0 && !ready_i && exp_cnt != CNT_MAX) exp_cnt++;
        if (flush_i) exp_q.delete();
        else begin
          if (exp_q.size() > 0 && ready_i) void'(exp_q.pop_front());
          if (valid_i && rdy_now) exp_q.push_back(in_b);
        end
        if (exp_q.size() > 0) last_beat = exp_q[0];
      end
    end
  end

  // compare process: every negedge
  initial begin
    logic v;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      v = exp_q.size() > 0;
      exp_rdy = SKID ? (exp_q.size() < 2) : (exp_q.size() == 0 || ready_i);
      chk("valid_o", valid_o, v);
      chk("ready_o", ready_o, exp_rdy);
      chk("ctrl_o", ctrl_o, v ? last_beat.ctrl : 5'd0);
      chk("alu_result_o", alu_result_o, last_beat.alu);
      chk("rs2_data_o", rs2_data_o, last_beat.rs2);
      chk("pc_branch_o", pc_branch_o, last_beat.pc);
      chk("zero_o", zero_o, last_beat.zero);
      chk("rd_addr_o", rd_addr_o, last_beat.rd);
      chk("branch_taken_o", branch_taken_o, v & last_beat.ctrl[4] & last_beat.zero);
      chk("stall_cnt_o", stall_cnt_o, exp_cnt);
    end
  end

  // driver tasks
  task automatic set_beat(input logic [31:0] alu, input logic [4:0] ctrl, input logic z,
                          input logic [31:0] pc);
    valid_i = 1'b1;
    alu_result_i = alu;
    rs2_data_i = alu ^ 32'h5A5A_0000;
    pc_branch_i = pc;
    zero_i = z;
    ctrl_i = ctrl;
    rd_addr_i = alu[4:0] ^ 5'h1F;
  endtask

  task automatic step();
    logic acc;
    @(negedge clk);
    acc = valid_i && ready_o && !flush_i;
    @(posedge clk);
    #1;
    if (acc) valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] rdy_pat = 32'b1011_0010_1110_0001_1001_1000_1111_0100;
  logic [31:0] vld_pat = 32'b1110_1111_0111_1011_1100_1111_1011_1110;
  logic [31:0] fl_pat  = 32'b0000_0000_0100_0000_0000_0100_0000_0000;

  initial begin
    do_reset();
    chk("reset_valid", valid_o, 1'b0);
    chk("reset_stall", stall_cnt_o, '0);

    // streaming 1..8
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      set_beat(32'(i), 5'b00001, 1'b0, 32'h0);
      step();
      chk("stream_valid", valid_o, 1'b1);
      chk("stream_alu", alu_result_o, 32'(i));
    end
    step();
    chk("stream_drain", valid_o, 1'b0);

    // backpressure
    do_reset();
    ready_i = 1'b0;
    set_beat(32'hA5A5_A5A5, 5'b00011, 1'b0, 32'h0);
    step();
    set_beat(32'h0000_0011, 5'b00001, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", alu_result_o, 32'hA5A5_A5A5);
    end
    chk("bp_stall5", stall_cnt_o, 4'd5);
    ready_i = 1'b1;
    step();
    chk("bp_next", alu_result_o, 32'h0000_0011);
    chk("bp_next_valid", valid_o, 1'b1);

    // asynchronous reset mid-cycle while a beat is held
    ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_ctrl", ctrl_o, 5'd0);
    chk("arst_stall", stall_cnt_o, '0);
    chk("arst_alu", alu_result_o, 32'h0);
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_i = 1'b1;

    // flush
    set_beat(32'h77, 5'b00001, 1'b0, 32'h0);
    step();
    chk("fl_accept_ctrl", ctrl_o, 5'b00001);
    set_beat(32'h88, 5'b00001, 1'b0, 32'h0);
    flush_i = 1'b1;
    step();
    chk("fl_valid", valid_o, 1'b0);
    chk("fl_ctrl", ctrl_o, 5'd0);
    flush_i = 1'b0;
    valid_i = 1'b0;
    step();
    chk("fl_empty", valid_o, 1'b0);

    // branch
    set_beat(32'h1, 5'b10000, 1'b1, 32'h40);
    step();
    chk("br_taken", branch_taken_o, 1'b1);
    chk("br_pc", pc_branch_o, 32'h40);
    set_beat(32'h2, 5'b10000, 1'b0, 32'h40);
    step();
    chk("br_not_taken", branch_taken_o, 1'b0);
    step();
    chk("br_empty", branch_taken_o, 1'b0);

    // saturation
    do_reset();
    ready_i = 1'b0;
    set_beat(32'h5, 5'b00001, 1'b0, 32'h0);
    step();
    repeat (20) step();
    chk("sat_15", stall_cnt_o, 4'd15);
    ready_i = 1'b1;
    step();
    chk("sat_hold", stall_cnt_o, 4'd15);

    // mixed ready/valid/flush pattern, checked by the model every cycle
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (!valid_i && vld_pat[i]) set_beat(32'h100 + 32'(i), 5'(i * 7), i[0], 32'h1000 + 32'(i));
      ready_i = rdy_pat[i];
      flush_i = fl_pat[i];
      step();
    end
    flush_i = 1'b0;
    ready_i = 1'b1;
    valid_i = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result, RS2 data and branch target.
REQ-002 Parameter CTRL_W, default 5, control bits {Branch, MemRead, MemtoReg, MemWrite, RegWrite}, bit 0 = RegWrite, bit 4 = Branch.
REQ-003 Parameter RD_W, default 5, destination register address width.
REQ-004 Parameter CNT_W, default 16, stall counter width.
REQ-005 clk_i  input  1  clock; all state on rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 valid_i  input  1  EX beat present.
REQ-008 ready_o  output  1  stage accepts EX beat this cycle.
REQ-009 flush_i  input  1  kill all held and incoming beats.
REQ-010 alu_result_i / rs2_data_i / pc_branch_i  input  DATA_W each  EX datapath.
REQ-011 zero_i  input  1  ALU zero flag.
REQ-012 ctrl_i  input  CTRL_W  control bits.
REQ-013 rd_addr_i  input  RD_W  destination register.
REQ-014 valid_o  output  1  MEM beat present.
REQ-015 ready_i  input  1  MEM stage consumes beat.
REQ-016 alu_result_o / rs2_data_o / pc_branch_o / zero_o / ctrl_o / rd_addr_o  output  as inputs  registered copies.
REQ-017 branch_taken_o  output  1  valid_o & ctrl_o[4] & zero_o.
REQ-018 stall_cnt_o  output  CNT_W  cycles with valid_o=1 and ready_i=0.

Function
REQ-019 Transfer in occurs when valid_i & ready_o & ~flush_i; transfer out when valid_o & ready_i.
REQ-020 Base mode: ready_o = ready_i | ~valid_o (combinational); accepted beat appears on outputs next cycle, latency 1.
REQ-021 valid_o=1 and ready_i=0: all outputs held stable, no beat dropped or duplicated.
REQ-022 Simultaneous transfer out and transfer in: new beat replaces old at next edge, valid_o stays 1.
REQ-023 Transfer out without transfer in: valid_o clears next edge, ctrl_o cleared to 0.
REQ-024 ctrl_o SHALL be all-zero whenever valid_o=0; data outputs hold last value when empty.
REQ-025 flush_i=1: next edge valid_o=0, ctrl_o=0, skid entry emptied, incoming beat dropped, regardless of valid_i/ready_i.
REQ-026 stall_cnt_o increments by 1 each cycle valid_o & ~ready_i, saturates at all-ones, never wraps; flush does not clear it.
REQ-027 branch_taken_o purely combinational from registered outputs, 0 when valid_o=0.

Reset
REQ-028 rst_n_i low: immediately valid_o=0, all data, ctrl, rd_addr, zero_o, branch_taken_o, stall_cnt_o = 0, skid entry empty.
REQ-029 Reset asserted mid-transfer discards all beats; first accept possible on first rising edge after deassertion.

Configuration
REQ-030 Macro EX_MEM_PIPE_SKID_EN defined: one-entry skid buffer added; ready_o driven directly from a flop, equal to ~skid_full.
REQ-031 With skid: beat accepted while output stalled goes to skid; on ready_i the skid beat moves to outputs next edge, order preserved; throughput 1 beat/cycle when ready_i=1.
REQ-032 With skid: ready_o=0 only when both output register and skid are full; stall_cnt_o counts output-register stalls only.
REQ-033 Macro undefined: no skid storage, REQ-020 combinational ready_o, identical output timing otherwise.

Verification
REQ-034 Reset: rst_n_i low mid-run with valid_o=1 -> valid_o=0, ctrl_o=0, stall_cnt_o=0 before next clock edge.
REQ-035 Streaming: 8 beats alu_result_i=1..8, ready_i=1 -> alu_result_o=1..8 on consecutive cycles, latency 1.
REQ-036 Backpressure: ready_i=0 for 5 cycles with beat 0xA5A5A5A5 held -> output stable, stall_cnt_o=5, no loss; with skid, next beat emerges right after.
REQ-037 Flush: beat ctrl_i=5'b00001 accepted, flush_i pulsed together with new valid_i -> valid_o=0, ctrl_o=0 next cycle, neither beat appears.
REQ-038 Branch: ctrl_i[4]=1, zero_i=1, pc_branch_i=0x40 -> branch_taken_o=1, pc_branch_o=0x40; zero_i=0 -> branch_taken_o=0.
REQ-039 Saturation: CNT_W=4, ready_i=0 for 20 cycles -> stall_cnt_o stops at 15.
